// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the sprite/pixel pipeline: default pixel width,
// the transparency colour key, layer field width and the arbiter FSM states.
// ---------------------------------------------------------------------------
package gpu_pkg;

  // Default RGB444 pixel width used by the pixel path.
  localparam int PIXEL_W_DEF = 12;

  // Sprite pixels equal to this key are see-through.
  localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;

  // Width of each sprite's layer number; a higher value is drawn on top.
  localparam int LAYER_W = 2;

  // Pixel arbiter sequence: sample, read A, read B, resolve.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD1     = 2'd1,
    ST_RD2     = 2'd2,
    ST_RESOLVE = 2'd3
  } arb_state_e;

endpackage : gpu_pkg

// File: rtl/layer_priority_encoder.sv
// ---------------------------------------------------------------------------
// layer_priority_encoder
// Combinational selection of the topmost (A) and second-topmost (B)
// requesting sprite. The highest layer wins; equal layers go to the lowest
// index.
// Ports:
//   req_i     - request vector, bit i from sprite i
//   layer_i   - packed layers, slice i is [LAYER_W*i +: LAYER_W]
//   a_idx_o   - winner index,    a_valid_o - winner exists
//   b_idx_o   - runner-up index, b_valid_o - runner-up exists
// ---------------------------------------------------------------------------
module layer_priority_encoder
  import gpu_pkg::*;
#(
  parameter  int NUM_SPRITES = 4,
  localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic [NUM_SPRITES-1:0]         req_i,
  input  logic [NUM_SPRITES*LAYER_W-1:0] layer_i,
  output logic [IDX_W-1:0]               a_idx_o,
  output logic                           a_valid_o,
  output logic [IDX_W-1:0]               b_idx_o,
  output logic                           b_valid_o
);

  logic [IDX_W-1:0]   a_idx_s;
  logic               a_valid_s;
  logic [LAYER_W-1:0] a_lay_s;
  logic [IDX_W-1:0]   b_idx_s;
  logic               b_valid_s;
  logic [LAYER_W-1:0] b_lay_s;

  // Winner scan: strict greater-than keeps the lowest index on layer ties.
  always_comb begin
    a_idx_s   = '0;
    a_valid_s = 1'b0;
    a_lay_s   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (req_i[i] && (!a_valid_s || (layer_i[LAYER_W*i +: LAYER_W] > a_lay_s))) begin
        a_idx_s   = IDX_W'(i);
        a_valid_s = 1'b1;
        a_lay_s   = layer_i[LAYER_W*i +: LAYER_W];
      end else begin
        a_idx_s   = a_idx_s;
      end
    end
  end

  // Runner-up scan: same rule with the winner removed from the candidates.
  always_comb begin
    b_idx_s   = '0;
    b_valid_s = 1'b0;
    b_lay_s   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (req_i[i] && !(a_valid_s && (a_idx_s == IDX_W'(i))) &&
          (!b_valid_s || (layer_i[LAYER_W*i +: LAYER_W] > b_lay_s))) begin
        b_idx_s   = IDX_W'(i);
        b_valid_s = 1'b1;
        b_lay_s   = layer_i[LAYER_W*i +: LAYER_W];
      end else begin
        b_idx_s   = b_idx_s;
      end
    end
  end

  assign a_idx_o   = a_idx_s;
  assign a_valid_o = a_valid_s;
  assign b_idx_o   = b_idx_s;
  assign b_valid_o = b_valid_s;

endmodule : layer_priority_encoder

// File: rtl/pixel_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_arbiter
// Per 25 MHz pixel slot, picks the two topmost requesting sprites, reads
// their pixels from the shared sprite BRAM and resolves transparency into
// one registered RGB pixel.
// Ports:
//   clk, rst          - 100 MHz clock, async active-high reset
//   clk25en           - pixel-rate enable, 1 of every 4 cycles
//   req_in/addr_in/layer_in - per-sprite request, BRAM address, layer
//   blank, bg_color   - video blanking and background colour
//   ram_addr, ram_en  - BRAM read port (data returns one cycle later)
//   ram_data          - BRAM read data
//   pixel_rgb         - resolved pixel, held between updates
//   pixel_valid       - one-cycle pulse when pixel_rgb updates
//   overrun           - sticky: a request arrived while busy (dropped)
// ---------------------------------------------------------------------------
module pixel_arbiter
  import gpu_pkg::*;
#(
  parameter  int NUM_SPRITES   = 4,
  parameter  int ram_add_width = 8,
  parameter  int PIXEL_W       = PIXEL_W_DEF,
  localparam int IDX_W         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk25en,
  input  logic [NUM_SPRITES-1:0]             req_in,
  input  logic [NUM_SPRITES*ram_add_width-1:0] addr_in,
  input  logic [NUM_SPRITES*LAYER_W-1:0]     layer_in,
  input  logic                               blank,
  input  logic [PIXEL_W-1:0]                 bg_color,
  output logic [ram_add_width-1:0]           ram_addr,
  output logic                               ram_en,
  input  logic [PIXEL_W-1:0]                 ram_data,
  output logic [PIXEL_W-1:0]                 pixel_rgb,
  output logic                               pixel_valid,
  output logic                               overrun
);

  arb_state_e state_q, state_d;
  logic       slot_q;
  logic       start_s;

  logic [IDX_W-1:0]         a_idx_s, b_idx_s;
  logic                     a_valid_s, b_valid_s;
  logic [ram_add_width-1:0] a_addr_s, b_addr_s;

  logic                     va_q, va_d, vb_q, vb_d, blank_q, blank_d;
  logic [ram_add_width-1:0] b_addr_q, b_addr_d;
  logic [PIXEL_W-1:0]       pix_a_q, pix_a_d;
  logic [ram_add_width-1:0] ram_addr_q, ram_addr_d;
  logic                     ram_en_q, ram_en_d;
  logic [PIXEL_W-1:0]       pixel_rgb_q, pixel_rgb_d;
  logic                     pixel_valid_q, pixel_valid_d;
  logic                     overrun_q, overrun_d;

  layer_priority_encoder #(.NUM_SPRITES(NUM_SPRITES)) u_prio (
    .req_i    (req_in),
    .layer_i  (layer_in),
    .a_idx_o  (a_idx_s),
    .a_valid_o(a_valid_s),
    .b_idx_o  (b_idx_s),
    .b_valid_o(b_valid_s)
  );

  // Address mux: pick the winner's and runner-up's address slices.
  always_comb begin
    a_addr_s = '0;
    b_addr_s = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (a_idx_s == IDX_W'(i)) begin
        a_addr_s = addr_in[i*ram_add_width +: ram_add_width];
      end else begin
        a_addr_s = a_addr_s;
      end
      if (b_idx_s == IDX_W'(i)) begin
        b_addr_s = addr_in[i*ram_add_width +: ram_add_width];
      end else begin
        b_addr_s = b_addr_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic. Read-port registers are loaded one
  // state early so that ram_addr/ram_en are valid during RD1 and RD2.
  always_comb begin
    state_d       = state_q;
    start_s       = 1'b0;
    va_d          = va_q;
    vb_d          = vb_q;
    blank_d       = blank_q;
    b_addr_d      = b_addr_q;
    pix_a_d       = pix_a_q;
    ram_addr_d    = ram_addr_q;
    ram_en_d      = 1'b0;
    pixel_rgb_d   = pixel_rgb_q;
    pixel_valid_d = 1'b0;
    // Requests are only accepted in IDLE; anything else is an overrun.
    overrun_d     = overrun_q | ((state_q != ST_IDLE) && (|req_in));
    case (state_q)
      ST_IDLE: begin
        if (slot_q || (|req_in)) begin
          start_s  = 1'b1;
          state_d  = ST_RD1;
          va_d     = a_valid_s;
          vb_d     = b_valid_s;
          blank_d  = blank;
          b_addr_d = b_addr_s;
          ram_en_d = a_valid_s;
          if (a_valid_s) begin
            ram_addr_d = a_addr_s;
          end else begin
            ram_addr_d = ram_addr_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD1: begin
        state_d  = ST_RD2;
        ram_en_d = vb_q;
        if (vb_q) begin
          ram_addr_d = b_addr_q;
        end else begin
          ram_addr_d = ram_addr_q;
        end
      end
      ST_RD2: begin
        state_d = ST_RESOLVE;
        pix_a_d = ram_data;
      end
      ST_RESOLVE: begin
        state_d       = ST_IDLE;
        pixel_valid_d = 1'b1;
        if (blank_q) begin
          pixel_rgb_d = '0;
        end else if (va_q && (pix_a_q != PIXEL_W'(TRANSPARENT_KEY))) begin
          pixel_rgb_d = pix_a_q;
        end else if (vb_q && (ram_data != PIXEL_W'(TRANSPARENT_KEY))) begin
          pixel_rgb_d = ram_data;
        end else begin
          pixel_rgb_d = bg_color;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= 1'b0;
      va_q          <= 1'b0;
      vb_q          <= 1'b0;
      blank_q       <= 1'b0;
      b_addr_q      <= '0;
      pix_a_q       <= '0;
      ram_addr_q    <= '0;
      ram_en_q      <= 1'b0;
      pixel_rgb_q   <= '0;
      pixel_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      slot_q        <= clk25en;
      va_q          <= va_d;
      vb_q          <= vb_d;
      blank_q       <= blank_d;
      b_addr_q      <= b_addr_d;
      pix_a_q       <= pix_a_d;
      ram_addr_q    <= ram_addr_d;
      ram_en_q      <= ram_en_d;
      pixel_rgb_q   <= pixel_rgb_d;
      pixel_valid_q <= pixel_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_en      = ram_en_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign overrun     = overrun_q;

endmodule : pixel_arbiter
